// File: rtl/page_router_if.sv
// Page router bus: direct-select request, page pixels and buttons in,
// routed buttons, selected pixel and status out.
interface page_router_if #(
    parameter int NUM_PAGES = 4,
    parameter int PIX_W     = 12,
    parameter int BTN_W     = 16
) ();
    localparam int PW = $clog2(NUM_PAGES);

    logic                       sel_valid;
    logic [PW-1:0]              sel_page;
    logic [NUM_PAGES*PIX_W-1:0] pix_in;
    logic [BTN_W-1:0]           btns_in;
    logic [NUM_PAGES*BTN_W-1:0] btns_out;
    logic [PIX_W-1:0]           pix_out;
    logic [PW-1:0]              page_cur;
    logic                       switching;

    // Client side: issues selects and supplies page data.
    modport master (
        output sel_valid, sel_page, pix_in, btns_in,
        input  btns_out, pix_out, page_cur, switching
    );

    // Router side.
    modport slave (
        input  sel_valid, sel_page, pix_in, btns_in,
        output btns_out, pix_out, page_cur, switching
    );
endinterface

// File: rtl/page_router.sv
// Page router: debounced next/prev buttons and a direct-select strobe set a
// target page; the visible page only changes on a v_sync falling edge so a
// switch never tears mid-frame. Optional macro PAGE_BLANK_EN inserts one
// blanked frame (pix_out = 0, buttons gated off) after each switch.
module page_router #(
    parameter int NUM_PAGES  = 4,
    parameter int PIX_W      = 12,
    parameter int BTN_W      = 16,
    parameter int DEB_CYCLES = 50000
) (
    input  logic          vga_clk,
    input  logic          vga_rst,
    input  logic          btn_next,
    input  logic          btn_prev,
    input  logic          v_sync,
    page_router_if.slave  bus
);
    localparam int PW = $clog2(NUM_PAGES);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] LAST_PAGE = PW'(NUM_PAGES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

`ifdef PAGE_BLANK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, BLANK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1} state_t;
`endif

    // Wrapping page arithmetic.
    function automatic logic [PW-1:0] page_inc(input logic [PW-1:0] p);
        return (p == LAST_PAGE) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] page_dec(input logic [PW-1:0] p);
        return (p == '0) ? LAST_PAGE : p - 1'b1;
    endfunction

    // Index 0 = next, index 1 = prev.
    logic [1:0]    btn_raw;
    logic [1:0]    sync_p0;
    logic [1:0]    sync_p1;
    logic [CW-1:0] deb_cnt [2];
    logic [1:0]    accepted;
    logic [1:0]    pulse;

    logic [PW-1:0]    target;
    logic [PW-1:0]    page_reg;
    logic             vsync_q;
    logic             boundary;
    logic             sel_ok;
    logic             blank;
    logic             commit;
    state_t           state;
    state_t           state_nxt;
    logic [PIX_W-1:0] pix_sel;
    logic [PIX_W-1:0] pix_reg;
    logic [NUM_PAGES*BTN_W-1:0] btns_gated;

    assign btn_raw = {btn_prev, btn_next};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        // Two-flop synchroniser for the raw asynchronous button.
        always_ff @(posedge vga_clk or negedge vga_rst) begin
            if (!vga_rst) begin
                sync_p0[b] <= 1'b0;
                sync_p1[b] <= 1'b0;
            end else begin
                sync_p0[b] <= btn_raw[b];
                sync_p1[b] <= sync_p0[b];
            end
        end

        // Debounce: accept a new level after DEB_CYCLES consecutive samples
        // that disagree with the accepted one; pulse on an accepted rise.
        always_ff @(posedge vga_clk or negedge vga_rst) begin
            if (!vga_rst) begin
                deb_cnt[b]  <= '0;
                accepted[b] <= 1'b0;
                pulse[b]    <= 1'b0;
            end else begin
                pulse[b] <= 1'b0;
                if (sync_p1[b] == accepted[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_LAST) begin
                    deb_cnt[b]  <= '0;
                    accepted[b] <= sync_p1[b];
                    pulse[b]    <= sync_p1[b];
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    // An out-of-range direct select is dropped entirely.
    assign sel_ok = bus.sel_valid &&
                    ({1'b0, bus.sel_page} < (PW + 1)'(NUM_PAGES));

    // Target page: direct select wins, opposing button pulses cancel.
    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            target <= '0;
        end else if (sel_ok) begin
            target <= bus.sel_page;
        end else if (pulse[0] && !pulse[1]) begin
            target <= page_inc(target);
        end else if (pulse[1] && !pulse[0]) begin
            target <= page_dec(target);
        end
    end

    // Previous v_sync sample for falling-edge (frame boundary) detection.
    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= v_sync;
        end
    end

    assign boundary = vsync_q && !v_sync;

    // Switch FSM state register.
    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Switch FSM next state; commit only on a frame boundary while pending.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (target != page_reg) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (target == page_reg) begin
                    state_nxt = IDLE;
                end else if (boundary) begin
                    commit = 1'b1;
`ifdef PAGE_BLANK_EN
                    state_nxt = BLANK;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef PAGE_BLANK_EN
            BLANK: begin
                if (boundary) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Committed page register.
    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            page_reg <= '0;
        end else if (commit) begin
            page_reg <= target;
        end
    end

`ifdef PAGE_BLANK_EN
    assign blank = (state == BLANK);
`else
    assign blank = 1'b0;
`endif

    // Select the committed page's pixel slice.
    always_comb begin
        pix_sel = '0;
        for (int k = 0; k < NUM_PAGES; k++) begin
            if (PW'(k) == page_reg) begin
                pix_sel = bus.pix_in[k*PIX_W +: PIX_W];
            end
        end
    end

    // Registered pixel output, forced to zero while blanking.
    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            pix_reg <= '0;
        end else begin
            pix_reg <= blank ? '0 : pix_sel;
        end
    end

    // Route the shared buttons to the committed page only.
    always_comb begin
        btns_gated = '0;
        for (int k = 0; k < NUM_PAGES; k++) begin
            if (!blank && (PW'(k) == page_reg)) begin
                btns_gated[k*BTN_W +: BTN_W] = bus.btns_in;
            end
        end
    end

    assign bus.btns_out  = btns_gated;
    assign bus.pix_out   = pix_reg;
    assign bus.page_cur  = page_reg;
    assign bus.switching = (state != IDLE);
endmodule

// File: tb/tb_page_router.sv
// Directed bench for page_router (DEB_CYCLES=4, NUM_PAGES=4, PIX_W=12),
// plus a NUM_PAGES=3 instance for out-of-range select handling.
module tb_page_router;
    logic clk = 1'b0;
    logic rst_n;
    logic btn_next;
    logic btn_prev;
    logic v_sync;
    logic btn_idle;

    int n_cmp = 0;
    int n_bad = 0;

    page_router_if #(.NUM_PAGES(4), .PIX_W(12), .BTN_W(16)) bus ();
    page_router_if #(.NUM_PAGES(3), .PIX_W(12), .BTN_W(16)) bus3 ();

    page_router #(.NUM_PAGES(4), .PIX_W(12), .BTN_W(16), .DEB_CYCLES(4)) dut (
        .vga_clk  (clk),
        .vga_rst  (rst_n),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .v_sync   (v_sync),
        .bus      (bus)
    );

    page_router #(.NUM_PAGES(3), .PIX_W(12), .BTN_W(16), .DEB_CYCLES(4)) dut3 (
        .vga_clk  (clk),
        .vga_rst  (rst_n),
        .btn_next (btn_idle),
        .btn_prev (btn_idle),
        .v_sync   (v_sync),
        .bus      (bus3)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic nxt, input logic prv);
        btn_next = nxt;
        btn_prev = prv;
        repeat (10) tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (10) tick();
    endtask

    // One frame boundary (two with blanking, to leave the blank frame).
    task automatic frame();
        v_sync = 1'b0; tick();
        v_sync = 1'b1; tick();
`ifdef PAGE_BLANK_EN
        v_sync = 1'b0; tick();
        v_sync = 1'b1; tick();
`endif
    endtask

    task automatic select(input logic [1:0] p);
        bus.sel_page  = p;
        bus.sel_valid = 1'b1;
        tick();
        bus.sel_valid = 1'b0;
        tick();
        frame();
    endtask

    initial begin
        rst_n = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_idle = 1'b0;
        v_sync = 1'b1;
        bus.sel_valid = 1'b0;
        bus.sel_page = '0;
        bus.pix_in = {12'h444, 12'h333, 12'h222, 12'h111};
        bus.btns_in = 16'hABCD;
        bus3.sel_valid = 1'b0;
        bus3.sel_page = '0;
        bus3.pix_in = {12'h777, 12'h666, 12'h555};
        bus3.btns_in = 16'h0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_page", 64'(bus.page_cur), 64'd0);
        check_eq("rst_switching", 64'(bus.switching), 64'd0);
        check_eq("rst_pix", 64'(bus.pix_out), 64'd0);
        check_eq("rst_btns", bus.btns_out, 64'h0000_0000_0000_ABCD);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("idle_pix_page0", 64'(bus.pix_out), 64'h111);

        // Bounce rejection
        for (int i = 0; i < 40; i++) begin
            btn_next = ((i / 2) % 2 == 0);
            tick();
            check_eq("bounce_switching", 64'(bus.switching), 64'd0);
        end
        btn_next = 1'b0;
        repeat (10) tick();
        frame();
        check_eq("bounce_page", 64'(bus.page_cur), 64'd0);

        // Next press across a boundary
        press(1'b1, 1'b0);
        check_eq("next_pending", 64'(bus.switching), 64'd1);
        check_eq("next_no_early_commit", 64'(bus.page_cur), 64'd0);
        v_sync = 1'b0; tick();
        check_eq("next_commit_edge", 64'(bus.page_cur), 64'd1);
        v_sync = 1'b1; tick();
`ifdef PAGE_BLANK_EN
        check_eq("next_blank_pix", 64'(bus.pix_out), 64'd0);
        check_eq("next_blank_switching", 64'(bus.switching), 64'd1);
        check_eq("next_blank_btns", bus.btns_out, 64'd0);
        v_sync = 1'b0; tick();
        v_sync = 1'b1; tick();
`endif
        check_eq("next_pix", 64'(bus.pix_out), 64'h222);
        check_eq("next_done", 64'(bus.switching), 64'd0);

        // Wrap at both ends
        press(1'b0, 1'b1);
        frame();
        check_eq("prev_to_0", 64'(bus.page_cur), 64'd0);
        press(1'b0, 1'b1);
        frame();
        check_eq("wrap_prev_page", 64'(bus.page_cur), 64'd3);
        check_eq("wrap_prev_pix", 64'(bus.pix_out), 64'h444);
        press(1'b1, 1'b0);
        frame();
        check_eq("wrap_next_page", 64'(bus.page_cur), 64'd0);

        // Select priority over a coincident next pulse
        btn_next = 1'b1;
        repeat (4) tick();
        bus.sel_page = 2'd2;
        bus.sel_valid = 1'b1;
        repeat (5) tick();
        bus.sel_valid = 1'b0;
        repeat (1) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        frame();
        check_eq("sel_prio_page", 64'(bus.page_cur), 64'd2);
        check_eq("sel_prio_pix", 64'(bus.pix_out), 64'h333);

        // Out-of-range select on the 3-page instance, then a legal one
        bus3.sel_page = 2'd3;
        bus3.sel_valid = 1'b1;
        tick();
        bus3.sel_valid = 1'b0;
        tick();
        check_eq("sel_range_switching", 64'(bus3.switching), 64'd0);
        frame();
        check_eq("sel_range_page", 64'(bus3.page_cur), 64'd0);
        bus3.sel_page = 2'd2;
        bus3.sel_valid = 1'b1;
        tick();
        bus3.sel_valid = 1'b0;
        tick();
        frame();
        check_eq("sel3_legal_page", 64'(bus3.page_cur), 64'd2);

        // Simultaneous next and prev
        press(1'b1, 1'b1);
        check_eq("simul_switching", 64'(bus.switching), 64'd0);
        frame();
        check_eq("simul_page", 64'(bus.page_cur), 64'd2);

        // Cancel before a boundary
        press(1'b1, 1'b0);
        check_eq("cancel_pend", 64'(bus.switching), 64'd1);
        press(1'b0, 1'b1);
        check_eq("cancel_idle", 64'(bus.switching), 64'd0);
        frame();
        check_eq("cancel_page", 64'(bus.page_cur), 64'd2);

        // Mid-switch reset
        select(2'd0);
        check_eq("pre_rst_page", 64'(bus.page_cur), 64'd0);
        bus.sel_page = 2'd2;
        bus.sel_valid = 1'b1;
        tick();
        bus.sel_valid = 1'b0;
        tick();
        check_eq("mid_rst_pend", 64'(bus.switching), 64'd1);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_page", 64'(bus.page_cur), 64'd0);
        check_eq("mid_rst_switching", 64'(bus.switching), 64'd0);
        check_eq("mid_rst_pix", 64'(bus.pix_out), 64'd0);
        rst_n = 1'b1;
        tick();
        frame();
        check_eq("post_rst_page", 64'(bus.page_cur), 64'd0);
        check_eq("post_rst_switching", 64'(bus.switching), 64'd0);

        // Button routing
        select(2'd1);
        check_eq("route_page", 64'(bus.page_cur), 64'd1);
        bus.btns_in = 16'h0001;
        #1;
        check_eq("route_btns", bus.btns_out, 64'h0000_0000_0001_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/page_router.md
PAGE_ROUTER -- requirements
Module: page_router

Interface
REQ-001 SHALL have parameter NUM_PAGES, default 4, number of selectable pages (legal 2..16).
REQ-002 SHALL have parameter PIX_W, default 12, pixel width per page.
REQ-003 SHALL have parameter BTN_W, default 16, button-vector width routed to pages.
REQ-004 SHALL have parameter DEB_CYCLES, default 50000, consecutive stable samples needed to accept a button level.
REQ-005 SHALL define PW = clog2(NUM_PAGES), the page index width.
REQ-006 SHALL have ports as listed below.
- vga_clk  in  1  sole clock.
- vga_rst  in  1  asynchronous, active-low reset.
- btn_next  in  1  raw, asynchronous "next page" button.
- btn_prev  in  1  raw, asynchronous "previous page" button.
- sel_valid  in  1  direct-select strobe, synchronous.
- sel_page  in  PW  direct-select target.
- v_sync  in  1  active-low frame sync from VGA timing.
- pix_in  in  NUM_PAGES*PIX_W  flattened page pixels; page k occupies bits [k*PIX_W +: PIX_W].
- btns_in  in  BTN_W  shared button vector.
- btns_out  out  NUM_PAGES*BTN_W  per-page gated buttons.
- pix_out  out  PIX_W  selected pixel, registered.
- page_cur  out  PW  committed page index.
- switching  out  1  high while a change is pending or blanking.

Function
REQ-007 SHALL synchronise each raw button through 2 flops, then debounce: the accepted level changes only after DEB_CYCLES consecutive equal synchronised samples.
REQ-008 SHALL generate a 1-cycle pulse on each 0->1 transition of an accepted level; a held button yields exactly one pulse.
REQ-009 SHALL keep a target register: next pulse sets target=(target+1) mod NUM_PAGES, prev pulse sets target=(target-1) mod NUM_PAGES, with wrap at both ends.
REQ-010 SHALL give sel_valid priority over next/prev in the same cycle; target=sel_page.
REQ-011 SHALL ignore sel_valid when sel_page >= NUM_PAGES; target unchanged.
REQ-012 SHALL leave target unchanged when next and prev pulse in the same cycle.
REQ-013 SHALL detect the frame boundary as a v_sync 1->0 edge (registered compare, 1 cycle).
REQ-014 SHALL implement an FSM with states IDLE, PEND and BLANK.
- IDLE->PEND when target != page_cur.
- PEND->IDLE when target == page_cur again before a boundary (cancelled).
- PEND at boundary: page_cur<=target; go to BLANK (PAGE_BLANK_EN) or IDLE.
- BLANK->IDLE at the next boundary.
REQ-015 SHALL accept requests in any state; a target changed during BLANK commits at a later boundary via PEND.
REQ-016 SHALL register pix_out: pix_out <= pix_in slice[page_cur], 1-cycle latency, or 0 during BLANK.
REQ-017 SHALL drive btns_out combinationally: slice[page_cur]=btns_in, all other slices 0; all slices 0 in BLANK.
REQ-018 SHALL assert switching iff state != IDLE.
REQ-019 SHALL never let page_cur change except on a boundary cycle.

Reset
REQ-020 SHALL, while vga_rst=0, clear the following:
- page_cur, target, pix_out, all debounce counters and accepted levels, pulses: 0.
- v_sync edge register: 1.
- state: IDLE.
- btns_out: slice0=btns_in, others 0.
REQ-021 SHALL abandon any pending or blanking switch when reset asserts mid-operation; no commit on release.

Configuration
REQ-022 SHALL compile the BLANK state and pix/btn blanking only when macro PAGE_BLANK_EN is defined; without it, PEND->IDLE directly at the boundary, switching deasserts that cycle, and pix_out never forces 0.

Verification (DEB_CYCLES=4, NUM_PAGES=4, PIX_W=12)
REQ-023 SHALL cover the following directed scenarios.
- Next press across a boundary: pix_in page0=12'h111, page1=12'h222; btn_next high 10 cycles, then v_sync falling -> page_cur 0->1 on the edge cycle. Without PAGE_BLANK_EN, pix_out=12'h222 one cycle later. With it, pix_out=0 for one frame, then 12'h222.
- Bounce rejection: btn_next toggling every 2 cycles for 40 cycles -> no pulse, target stays 0, switching stays 0.
- Wrap: prev from page 0 -> page 3 after boundary; then next -> page 0.
- Select priority: sel_valid=1, sel_page=2 in the same cycle as a next pulse, from page 0 -> page 2. sel_page=2'd3 with NUM_PAGES=3 -> ignored.
- Simultaneous and cancel cases:
  - next+prev in the same cycle -> no change.
  - next then prev before a boundary -> PEND->IDLE, page_cur unchanged.
- Mid-switch reset: vga_rst low while PEND (target=2) -> page_cur=0, switching=0, pix_out=0; no commit after release.
- Button routing: page_cur=1, btns_in=16'h0001 -> btns_out slice1=16'h0001, slices 0, 2 and 3 = 0.
